matdet_seq: RTL and testbench



---
 rtl/matdet_seq.sv | 157 +++++++++++++++
 tb/tb_matdet_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/matdet_seq.sv
// Sequential N x N determinant engine: one multiplier walks all N! Leibniz terms
// in Heap's permutation order, accumulating with alternating sign modulo 2^DATA_WIDTH.
module matdet_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N*N*DATA_WIDTH-1:0]      a,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          det,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] KLAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] m_r [N][N];
  logic [IW-1:0]         p_r [N];
  logic [IW-1:0]         c_r [N];
  logic [IW-1:0]         k_r;
  logic                  sign_r;
  logic [DATA_WIDTH-1:0] acc_r, prod_r, det_r, acc_s;
  logic                  in_ready_r, out_valid_r, busy_r;
  logic                  found_s;
  logic [IW-1:0]         idx_s, swap_s;

  // Heap step search: lowest i with c[i] < i, plus its swap partner.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = N - 1; i >= 1; i--) begin
      if (c_r[i] < IW'(i)) begin
        found_s = 1'b1;
        idx_s   = IW'(i);
      end else begin
        found_s = found_s;
      end
    end
    if (idx_s[0]) begin
      swap_s = c_r[idx_s];
    end else begin
      swap_s = '0;
    end
    if (sign_r) begin
      acc_s = acc_r + prod_r;
    end else begin
      acc_s = acc_r - prod_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = PROD;
        else          state_s = IDLE;
      end
      PROD: begin
        if (k_r == KLAST) state_s = STEP;
        else              state_s = PROD;
      end
      STEP: begin
        if (found_s) state_s = PROD;
        else         state_s = DONE;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == PROD) || (state_s == STEP);
    end
  end

  // Datapath: matrix capture, product chain, accumulation and Heap bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r  <= '0;
      det_r  <= '0;
      prod_r <= DATA_WIDTH'(1);
      k_r    <= '0;
      sign_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                m_r[r][c] <= a[(r*N+c)*DATA_WIDTH +: DATA_WIDTH];
              end
              p_r[r] <= IW'(r);
              c_r[r] <= '0;
            end
            acc_r  <= '0;
            prod_r <= DATA_WIDTH'(1);
            k_r    <= '0;
            sign_r <= 1'b1;
          end
        end
        PROD: begin
          prod_r <= prod_r * m_r[k_r][p_r[k_r]];
          k_r    <= k_r + IW'(1);
        end
        STEP: begin
          acc_r <= acc_s;
          if (found_s) begin
            for (int j = 1; j < N; j++) begin
              if (IW'(j) < idx_s)       c_r[j] <= '0;
              else if (IW'(j) == idx_s) c_r[j] <= c_r[j] + IW'(1);
            end
            p_r[idx_s]  <= p_r[swap_s];
            p_r[swap_s] <= p_r[idx_s];
            sign_r      <= ~sign_r;
            prod_r      <= DATA_WIDTH'(1);
            k_r         <= '0;
          end else begin
            det_r <= acc_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign det       = det_r;

endmodule

// File: tb/tb_matdet_seq.sv
// Bench for matdet_seq: one lane per (N, DATA_WIDTH) configuration, each running
// table vectors, backpressure/reset sequences and random matrices against a Leibniz model.
module tb_matdet_seq;

  localparam int NL = 5;
  localparam int LN [NL] = '{1, 2, 3, 4, 5};
  localparam int LW [NL] = '{4, 8, 8, 8, 16};

  typedef struct {
    int n;
    int mode;   // 0 plain, 1 output backpressure, 2 reset mid-operation
    int exp;
    int el [25];
  } vec_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl [9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  task automatic chk(input int ln, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (N=%0d) at cycle %0d: got %0h, expected %0h", nm, ln, cyc, act, exp);
    end
  endtask

  initial begin
    tbl[0].n = 1; tbl[0].mode = 0; tbl[0].exp = 9;   tbl[0].el = '{0:9, default:0};
    tbl[1].n = 2; tbl[1].mode = 0; tbl[1].exp = 11;  tbl[1].el = '{0:3, 1:5, 2:2, 3:7, default:0};
    tbl[2].n = 2; tbl[2].mode = 0; tbl[2].exp = 255; tbl[2].el = '{0:0, 1:1, 2:1, 3:0, default:0};
    tbl[3].n = 2; tbl[3].mode = 0; tbl[3].exp = 0;   tbl[3].el = '{0:16, 1:0, 2:0, 3:16, default:0};
    tbl[4].n = 2; tbl[4].mode = 1; tbl[4].exp = 11;  tbl[4].el = '{0:3, 1:5, 2:2, 3:7, default:0};
    tbl[5].n = 3; tbl[5].mode = 2; tbl[5].exp = 18;
    tbl[5].el = '{0:2, 1:0, 2:1, 3:1, 4:3, 5:2, 6:1, 7:1, 8:4, default:0};
    tbl[6].n = 3; tbl[6].mode = 0; tbl[6].exp = 18;
    tbl[6].el = '{0:2, 1:0, 2:1, 3:1, 4:3, 5:2, 6:1, 7:1, 8:4, default:0};
    tbl[7].n = 4; tbl[7].mode = 0; tbl[7].exp = 1;   tbl[7].el = '{0:1, 5:1, 10:1, 15:1, default:0};
    tbl[8].n = 4; tbl[8].mode = 0; tbl[8].exp = 0;
    tbl[8].el = '{0:1, 1:2, 2:3, 3:4, 4:1, 5:2, 6:3, 7:4, 8:5, 9:6, 10:7, 11:9, 12:2, 13:0, 14:1, 15:3, default:0};
  end

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int NN  = LN[g];
    localparam int DW  = LW[g];
    localparam int LAT = fact(NN) * (NN + 1);

    logic                  rst_n;
    logic [NN*NN*DW-1:0]   a;
    logic                  in_valid, in_ready, out_valid, out_ready, busy;
    logic [DW-1:0]         det;
    logic [DW-1:0]         sb [$];
    bit                    fin = 1'b0;

    matdet_seq #(.DATA_WIDTH(DW), .N(NN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .det       (det),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
    );

    // Wrapping Leibniz reference: enumerate all index tuples, keep permutations, sign by inversions.
    function automatic logic [DW-1:0] ref_det(input logic [NN*NN*DW-1:0] m);
      logic [DW-1:0] acc, pr;
      int tot, x, inv;
      int d [8];
      bit ok;
      acc = '0;
      tot = 1;
      for (int i = 0; i < NN; i++) tot = tot * NN;
      for (int t = 0; t < tot; t++) begin
        x = t; ok = 1'b1; inv = 0;
        for (int k = 0; k < NN; k++) begin
          d[k] = x % NN;
          x = x / NN;
        end
        for (int i = 0; i < NN; i++)
          for (int j = i + 1; j < NN; j++) begin
            if (d[i] == d[j]) ok = 1'b0;
            if (d[i] > d[j]) inv++;
          end
        if (ok) begin
          pr = DW'(1);
          for (int k = 0; k < NN; k++) pr = pr * m[(k*NN+d[k])*DW +: DW];
          acc = (inv % 2 == 1) ? acc - pr : acc + pr;
        end
      end
      return acc;
    endfunction

    task automatic run(input logic [NN*NN*DW-1:0] mat, input logic [DW-1:0] expv, input int mode);
      int t0, lat;
      logic [DW-1:0] e;
      bit ov_seen;
      a = mat;
      in_valid = 1'b1;
      sb.push_back(expv);
      @(posedge clk); #1;
      t0 = cyc;
      in_valid = 1'b0;
      a = ~mat;
      chk(NN, "busy_after_accept", busy, 1);
      chk(NN, "in_ready_low_after_accept", in_ready, 0);
      if (mode == 2) begin
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk(NN, "midrst_out_valid", out_valid, 0);
        chk(NN, "midrst_det", det, 0);
        chk(NN, "midrst_in_ready", in_ready, 1);
        chk(NN, "midrst_busy", busy, 0);
        void'(sb.pop_back());
        ov_seen = 1'b0;
        repeat (30) begin @(posedge clk); #1; ov_seen |= out_valid; end
        chk(NN, "midrst_no_out_valid", ov_seen, 0);
        return;
      end
      while (!out_valid && (cyc - t0) < 2 * LAT + 10) begin
        chk(NN, "busy_during_compute", busy, 1);
        @(posedge clk); #1;
      end
      lat = cyc - t0;
      chk(NN, "out_valid_seen", out_valid, 1);
      chk(NN, "latency", lat, LAT);
      chk(NN, "busy_in_done", busy, 0);
      e = sb.pop_front();
      chk(NN, "det", det, e);
      if (mode == 1) begin
        for (int h = 0; h < 5; h++) begin
          in_valid = ~in_valid;
          @(posedge clk); #1;
          chk(NN, "bp_det_hold", det, e);
          chk(NN, "bp_out_valid_hold", out_valid, 1);
          chk(NN, "bp_in_ready_low", in_ready, 0);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk(NN, "in_ready_after_handshake", in_ready, 1);
      chk(NN, "out_valid_after_handshake", out_valid, 0);
      @(posedge clk); #1;
      chk(NN, "idle_not_busy", busy, 0);
    endtask

    initial begin
      logic [NN*NN*DW-1:0] mat;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(NN, "reset_in_ready", in_ready, 1);
      chk(NN, "reset_out_valid", out_valid, 0);
      chk(NN, "reset_busy", busy, 0);
      chk(NN, "reset_det", det, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (tbl[i].n == NN) begin
          for (int k = 0; k < NN * NN; k++) mat[k*DW +: DW] = DW'(tbl[i].el[k]);
          run(mat, DW'(tbl[i].exp), tbl[i].mode);
        end
      end
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < NN * NN; k++) mat[k*DW +: DW] = DW'($urandom);
        run(mat, ref_det(mat), 0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    while (!(lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin && lane[4].fin) && cyc < 60000)
      @(posedge clk);
    if (!(lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin && lane[4].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: lanes still running at cycle %0d, required all finished", cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
